ifid_fetch_buffer: RTL and testbench

- Sits between the instruction-fetch stage and the decode stage of the MiniMIPS32 pipeline.
- Pairs each synchronous-read instruction-memory result with the PC that fetched it, one cycle later.
- Queues these pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Back-pressures fetch through a stall signal and discards all queued and in-flight fetches on a pipeline flush (branch/jump redirect).

---
 rtl/ifid_fetch_buffer.sv | 70 +++++++
 tb/tb_ifid_fetch_buffer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ifid_fetch_buffer.sv
// ifid_fetch_buffer: pairs fetched PCs with imem read data and queues them for decode
module ifid_fetch_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
) (
   input  logic                     cpu_clk_50M,
   input  logic                     cpu_rst_n,
   input  logic                     ice_i,
   input  logic [ADDR_W-1:0]        pc_i,
   input  logic [INST_W-1:0]        inst_i,
   input  logic                     flush_i,
   output logic                     stall_o,
   output logic                     id_valid_o,
   output logic [ADDR_W-1:0]        id_pc_o,
   output logic [INST_W-1:0]        id_inst_o,
   input  logic                     id_ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PW = $clog2(DEPTH);

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [PW:0]       count;
   logic [PW+1:0]     occ;
   logic              inflight;
   logic [ADDR_W-1:0] pc_d1;
   logic              accept, push, pop;

   assign occ        = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
   assign stall_o    = occ >= (PW+2)'(DEPTH);
   assign accept     = ice_i & ~stall_o & ~flush_i;
   assign push       = inflight & ~flush_i;
   assign id_valid_o = count != '0;
   assign pop        = id_valid_o & id_ready_i & ~flush_i;
   assign id_pc_o    = id_valid_o ? pc_mem[rd_ptr] : '0;
   assign id_inst_o  = id_valid_o ? inst_mem[rd_ptr] : '0;
   assign count_o    = count;

   // storage array: capture the delayed PC with the instruction that just returned
   always_ff @(posedge cpu_clk_50M) begin
      if (push) begin
         pc_mem[wr_ptr]   <= pc_d1;
         inst_mem[wr_ptr] <= inst_i;
      end
   end

   // fetch tracking, pointers and occupancy; flush drops everything queued or in flight
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= 1'b0;
         pc_d1    <= '0;
      end else if (flush_i) begin
         rd_ptr   <= wr_ptr;
         count    <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= accept;
         if (accept) pc_d1 <= pc_i;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (push & ~pop) count <= count + (PW+1)'(1);
         else if (pop & ~push) count <= count - (PW+1)'(1);
      end
   end
endmodule

// File: tb/tb_ifid_fetch_buffer.sv
// tb_ifid_fetch_buffer: directed plus random stimulus checked against a queue-based reference model
module tb_ifid_fetch_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ice_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic [31:0] inst_i = '0;
   logic        flush_i = 1'b0;
   logic        id_ready_i = 1'b0;
   logic        stall_o, id_valid_o;
   logic [31:0] id_pc_o, id_inst_o;
   logic [2:0]  count_o;

   ifid_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
      .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .ice_i(ice_i), .pc_i(pc_i), .inst_i(inst_i),
      .flush_i(flush_i), .stall_o(stall_o), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
      .id_inst_o(id_inst_o), .id_ready_i(id_ready_i), .count_o(count_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [63:0] q[$];
   bit          pend = 0;
   logic [31:0] pend_pc = '0;
   bit          last_acc = 0;
   logic [31:0] cur_pc = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // one pipeline cycle: compare outputs, drive inputs, advance model, return imem data
   task automatic step(input bit ice, input logic [31:0] pc, input bit fl, input bit rdy);
      bit mstall, acc;
      @(negedge clk);
      mstall = (q.size() + int'(pend)) >= DEPTH;
      chk("valid", 64'(id_valid_o), 64'(q.size() != 0));
      chk("count", 64'(count_o), 64'(q.size()));
      chk("stall", 64'(stall_o), 64'(mstall));
      chk("pc",    64'(id_pc_o),   q.size() != 0 ? 64'(q[0][63:32]) : 64'd0);
      chk("inst",  64'(id_inst_o), q.size() != 0 ? 64'(q[0][31:0])  : 64'd0);
      ice_i = ice; pc_i = pc; flush_i = fl; id_ready_i = rdy;
      @(posedge clk);
      acc = ice & ~mstall & ~fl;
      if (fl) begin
         q.delete();
         pend = 0;
      end else begin
         if (rdy && q.size() != 0) void'(q.pop_front());
         if (pend) q.push_back({pend_pc, inst_i});
         pend = acc;
         if (acc) pend_pc = pc;
      end
      last_acc = acc;
      #1 inst_i = 32'hAA00_0000 | pc;
   endtask

   task automatic feed(input bit ice, input bit fl, input bit rdy);
      step(ice, cur_pc, fl, rdy);
      if (last_acc) cur_pc = cur_pc + 32'd4;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(id_valid_o), 64'd0);
      chk("rst_stall", 64'(stall_o), 64'd0);
      chk("rst_pc", 64'(id_pc_o), 64'd0);
      rst_n = 1'b1;
      // streaming with decode always ready
      for (int i = 0; i < 8; i++) feed(1, 0, 1);
      // decode blocked: fill to saturation, then drain
      for (int i = 0; i < 8; i++) feed(1, 0, 0);
      for (int i = 0; i < 3; i++) feed(0, 0, 1);
      for (int i = 0; i < 4; i++) feed(1, 0, 1);
      for (int i = 0; i < 6; i++) feed(0, 0, 1);
      // push and pop together at count 3
      for (int i = 0; i < 4; i++) feed(1, 0, 0);
      for (int i = 0; i < 4; i++) feed(1, 0, 1);
      for (int i = 0; i < 6; i++) feed(0, 0, 1);
      // flush with queue holding 0x10..0x1C and 0x20 presented
      cur_pc = 32'h10;
      for (int i = 0; i < 5; i++) feed(1, 0, 0);
      step(1, 32'h20, 1, 0);
      cur_pc = 32'h100;
      for (int i = 0; i < 6; i++) feed(1, 0, 1);
      for (int i = 0; i < 4; i++) feed(0, 0, 1);
      // ice toggling
      for (int i = 0; i < 10; i++) feed(i % 2 == 0, 0, 1);
      for (int i = 0; i < 3; i++) feed(0, 0, 1);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, cur_pc, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
         if (last_acc) cur_pc = $urandom & 32'hFFFF_FFFC;
      end
      for (int i = 0; i < 6; i++) feed(0, 0, 1);
      // asynchronous reset between edges with two entries queued
      cur_pc = 32'h0;
      for (int i = 0; i < 3; i++) feed(1, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(id_valid_o), 64'd0);
      chk("arst_count", 64'(count_o), 64'd0);
      chk("arst_stall", 64'(stall_o), 64'd0);
      q.delete();
      pend = 0;
      @(negedge clk);
      ice_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cur_pc = 32'h0;
      for (int i = 0; i < 6; i++) feed(1, 0, 1);
      for (int i = 0; i < 4; i++) feed(0, 0, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
